corefifo_wr_ptr_gen_vdma: RTL

Write-side pointer and flag generator for the VDMA asynchronous FIFO, and the producer of the Gray-coded pointers that the read domain converts back to binary. It runs entirely in the write clock domain. It keeps the binary write pointer and emits a registered, glitch-free Gray copy for clock-domain crossing. It also synchronises the incoming read Gray pointer and derives full, almost-full, fill count and overflow.

---
 rtl/corefifo_wr_ptr_gen_vdma.sv | 104 ++++++++++
 1 files changed

// File: rtl/corefifo_wr_ptr_gen_vdma.sv
// Write-side pointer/flag generator for the VDMA async FIFO: binary + registered Gray
// write pointer, read-pointer synchroniser, and full/almost-full/count/overflow flags.
module corefifo_wr_ptr_gen_vdma #(
  parameter int ADDRWIDTH    = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   rd_ptr_gray,
  output logic                 wr_en_mem,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic [ADDRWIDTH:0]   wr_ptr_gray,
  output logic                 full,
  output logic                 afull,
  output logic [ADDRWIDTH:0]   wr_cnt,
  output logic                 overflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [PW-1:0] THRESH    = PW'(AFULL_THRESH);
  // Full means the write Gray pointer equals the read Gray pointer with its top two bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(2'b11) << (PW - 2);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [PW-1:0] wr_cnt_q, wr_cnt_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];

  logic          acc_s;
  logic [PW-1:0] rq_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] diff_s;

  // Next-state: pointer advance, synchroniser shift, and flags computed from the post-write pointer.
  always_comb begin
    acc_s         = we & ~full_q;
    wbin_d        = acc_s ? (wbin_q + PW'(1)) : wbin_q;
    wr_ptr_gray_d = bin2gray(wbin_d);
    rq_s          = sync_q[SYNC_STAGES-1];
    rbin_s        = gray2bin(rq_s);
    diff_s        = wbin_d - rbin_s;
    full_d        = (wr_ptr_gray_d == (rq_s ^ FULL_MASK));
    afull_d       = (diff_s >= THRESH);
    wr_cnt_d      = diff_s;
    overflow_d    = we & full_q;
    sync_d[0]     = rd_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // State registers; every flop including the synchroniser clears on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbin_q        <= '0;
      wr_ptr_gray_q <= '0;
      wr_cnt_q      <= '0;
      full_q        <= 1'b0;
      afull_q       <= 1'b0;
      overflow_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wbin_q        <= wbin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      wr_cnt_q      <= wr_cnt_d;
      full_q        <= full_d;
      afull_q       <= afull_d;
      overflow_q    <= overflow_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign wr_en_mem   = we & ~full_q;
  assign wr_addr     = wbin_q[ADDRWIDTH-1:0];
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_q;
  assign afull       = afull_q;
  assign wr_cnt      = wr_cnt_q;
  assign overflow    = overflow_q;

endmodule
